// File: rtl/weight_stream_mem_if.sv
// Write, start and output-stream signals of weight_stream_mem, grouped as one bus.
// The master side is the weight store; the slave side is whoever loads weights and consumes beats.
interface weight_stream_mem_if #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_WEIGHTS = 30,
    parameter int WEIGHT_W    = 8,
    parameter int LANES       = 5
);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int IW = $clog2(NUM_WEIGHTS);
    localparam int NB = NUM_WEIGHTS / LANES;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    logic                      wr_en;
    logic [NW-1:0]             wr_neuron;
    logic [IW-1:0]             wr_idx;
    logic [WEIGHT_W-1:0]       wr_data;
    logic                      start;
    logic [NW-1:0]             start_neuron;
    logic                      cfg_twos;
    logic                      busy;
    logic                      err;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*WEIGHT_W-1:0] out_data;
    logic [BW-1:0]             out_beat;
    logic                      out_last;

    modport master (
        input  wr_en, wr_neuron, wr_idx, wr_data,
        input  start, start_neuron, cfg_twos, out_ready,
        output busy, err, out_valid, out_data, out_beat, out_last
    );

    modport slave (
        output wr_en, wr_neuron, wr_idx, wr_data,
        output start, start_neuron, cfg_twos, out_ready,
        input  busy, err, out_valid, out_data, out_beat, out_last
    );
endinterface

// File: rtl/weight_stream_mem.sv
// Run-time writable sign-magnitude weight store that streams one neuron row as
// LANES-wide beats over valid/ready, optionally converting each weight to two's complement.
module weight_stream_mem #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_WEIGHTS = 30,
    parameter int WEIGHT_W    = 8,
    parameter int LANES       = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    weight_stream_mem_if.master bus
);
    localparam int NW    = $clog2(NUM_NEURONS);
    localparam int IW    = $clog2(NUM_WEIGHTS);
    localparam int NB    = NUM_WEIGHTS / LANES;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int DEPTH = NUM_NEURONS * NUM_WEIGHTS;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = LANES * WEIGHT_W;

    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state, state_next;
    logic [WEIGHT_W-1:0] mem [DEPTH];
    logic [NW-1:0]       row_q;
    logic                twos_q;
    logic                busy_q;
    logic                err_q;
    logic                valid_q;
    logic [DW-1:0]       data_q;
    logic [BW-1:0]       beat_q;

    logic                wr_in_range, wr_ok, wr_bad;
    logic                start_in_range, start_bad;
    logic                accept_start, load_beat, finish;
    logic [AW-1:0]       wr_addr, rd_base;
    logic [BW-1:0]       next_beat;
    logic [DW-1:0]       load_data;

    function automatic logic [WEIGHT_W-1:0] to_out(input logic [WEIGHT_W-1:0] w,
                                                   input logic                twos);
        // Negating {0, mag} maps negative zero to 0 and cannot overflow.
        if (twos && w[WEIGHT_W-1]) return WEIGHT_W'(-{1'b0, w[WEIGHT_W-2:0]});
        return w;
    endfunction

    assign wr_in_range    = ({1'b0, bus.wr_neuron} < (NW+1)'(NUM_NEURONS)) &&
                            ({1'b0, bus.wr_idx}    < (IW+1)'(NUM_WEIGHTS));
    assign wr_ok          = bus.wr_en && wr_in_range;
    assign wr_bad         = bus.wr_en && !wr_in_range;
    assign wr_addr        = AW'(bus.wr_neuron) * AW'(NUM_WEIGHTS) + AW'(bus.wr_idx);
    assign start_in_range = {1'b0, bus.start_neuron} < (NW+1)'(NUM_NEURONS);

    // NOTE: every storage word is cleared by reset, so this array cannot map onto a
    // reset-less RAM macro; that is accepted to guarantee all-zero rows after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        start_bad    = 1'b0;
        load_beat    = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (start_in_range) begin
                        accept_start = 1'b1;
                        state_next   = STREAM;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (!valid_q) begin
                    load_beat = 1'b1;
                end else if (bus.out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat data is read from the registered array, so a write on the loading edge is not seen.
    always_comb begin
        next_beat = valid_q ? beat_q + 1'b1 : '0;
        rd_base   = AW'(row_q) * AW'(NUM_WEIGHTS) + AW'(next_beat) * AW'(LANES);
        load_data = '0;
        for (int k = 0; k < LANES; k++) begin
            load_data[k*WEIGHT_W +: WEIGHT_W] = to_out(mem[rd_base + AW'(k)], twos_q);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            twos_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            beat_q  <= '0;
        end else begin
            err_q <= wr_bad || start_bad;
            if (accept_start) begin
                row_q  <= bus.start_neuron;
                twos_q <= bus.cfg_twos;
                busy_q <= 1'b1;
            end
            if (load_beat) begin
                data_q  <= load_data;
                beat_q  <= next_beat;
                valid_q <= 1'b1;
            end
            if (finish) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                beat_q  <= '0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_beat  = beat_q;
    assign bus.out_last  = valid_q && (beat_q == LAST_BEAT);
endmodule

// File: tb/tb_weight_stream_mem.sv
// Directed plus randomized bench for weight_stream_mem, checked against an array model
// of the weight rows and an arithmetic model of the sign-magnitude conversion.
module tb_weight_stream_mem;
    localparam int NN  = 10;
    localparam int NWT = 30;
    localparam int WW  = 8;
    localparam int LN  = 5;
    localparam int NB  = NWT / LN;
    localparam int NW  = $clog2(NN);
    localparam int IW  = $clog2(NWT);
    localparam int DW  = LN * WW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_stream_mem_if #(.NUM_NEURONS(NN), .NUM_WEIGHTS(NWT), .WEIGHT_W(WW), .LANES(LN)) bus ();

    weight_stream_mem #(.NUM_NEURONS(NN), .NUM_WEIGHTS(NWT), .WEIGHT_W(WW), .LANES(LN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WW-1:0] model [NN][NWT];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NWT; i++) model[n][i] = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_err"},   64'(bus.err), 64'd0);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_data"},  64'(bus.out_data), 64'd0);
        check({tag, "_beat"},  64'(bus.out_beat), 64'd0);
        check({tag, "_last"},  64'(bus.out_last), 64'd0);
    endtask

    // Signed value of a sign-magnitude word, wrapped to WW bits when twos is requested.
    function automatic logic [WW-1:0] ref_conv(input logic [WW-1:0] w, input bit twos);
        int mag;
        int v;
        if (!twos) return w;
        mag = int'(w[WW-2:0]);
        v   = w[WW-1] ? -mag : mag;
        return WW'(v);
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int row, input int beat, input bit twos);
        logic [DW-1:0] r;
        for (int k = 0; k < LN; k++) r[k*WW +: WW] = ref_conv(model[row][beat*LN + k], twos);
        return r;
    endfunction

    task automatic drive_wr(input int n, input int i, input logic [WW-1:0] d);
        bus.wr_en     = 1'b1;
        bus.wr_neuron = NW'(n);
        bus.wr_idx    = IW'(i);
        bus.wr_data   = d;
    endtask

    task automatic write_word(input int n, input int i, input logic [WW-1:0] d);
        bit bad;
        bad = (n >= NN) || (i >= NWT);
        drive_wr(n, i, d);
        step();
        bus.wr_en = 1'b0;
        if (!bad) model[n][i] = d;
        check("wr_err", 64'(bus.err), 64'(bad));
    endtask

    task automatic run_stream(input int row, input bit twos, input bit stall, input bit poke,
                              output logic [DW-1:0] first_d, output logic [DW-1:0] last_d);
        logic [DW-1:0] expb [NB];
        int beat;
        int p;
        int guard;
        bit rdy;
        first_d = '0;
        last_d  = '0;
        for (int b = 0; b < NB; b++) expb[b] = exp_beat(row, b, twos);
        bus.start        = 1'b1;
        bus.start_neuron = NW'(row);
        bus.cfg_twos     = twos;
        bus.out_ready    = 1'b0;
        step();
        bus.start    = 1'b0;
        bus.cfg_twos = ~twos;
        check("acc_busy", 64'(bus.busy), 64'd1);
        check("acc_valid", 64'(bus.out_valid), 64'd0);
        step();
        check("first_valid", 64'(bus.out_valid), 64'd1);
        beat  = 0;
        p     = 0;
        guard = 0;
        while (beat < NB && guard < 100) begin
            check("beat_data", 64'(bus.out_data), 64'(expb[beat]));
            check("beat_idx", 64'(bus.out_beat), 64'(beat));
            check("beat_last", 64'(bus.out_last), 64'(beat == NB - 1));
            check("beat_busy", 64'(bus.busy), 64'd1);
            if (beat == 0) first_d = bus.out_data;
            if (beat == NB - 1) last_d = bus.out_data;
            rdy = stall ? (p % 3 == 0) : 1'b1;
            p++;
            bus.out_ready = rdy;
            if (poke) begin
                bus.start        = 1'b1;
                bus.start_neuron = NW'((row + 1) % NN);
            end
            step();
            if (poke) check("poke_err", 64'(bus.err), 64'd0);
            if (rdy) beat++;
            guard++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_done", 64'(beat == NB), 64'd1);
        check("end_valid", 64'(bus.out_valid), 64'd0);
        check("end_busy", 64'(bus.busy), 64'd0);
        check("end_last", 64'(bus.out_last), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] f;
        logic [DW-1:0] l;
        int guard;

        bus.wr_en        = 1'b0;
        bus.wr_neuron    = '0;
        bus.wr_idx       = '0;
        bus.wr_data      = '0;
        bus.start        = 1'b0;
        bus.start_neuron = '0;
        bus.cfg_twos     = 1'b0;
        bus.out_ready    = 1'b0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Empty row after reset: six zero beats.
        run_stream(0, 1'b0, 1'b0, 1'b0, f, l);
        check("row0_first", 64'(f), 64'd0);
        check("row0_last", 64'(l), 64'd0);

        // Ramp row: lane 0 in the LSBs.
        for (int k = 0; k < NWT; k++) write_word(3, k, WW'(k));
        run_stream(3, 1'b0, 1'b0, 1'b0, f, l);
        check("row3_beat0", 64'(f), 64'h04_03_02_01_00);
        check("row3_beat5", 64'(l), 64'h1D_1C_1B_1A_19);

        // Two's complement conversion including negative zero and both extremes.
        write_word(1, 0, 8'h85);
        write_word(1, 1, 8'h80);
        write_word(1, 2, 8'h7F);
        write_word(1, 3, 8'hFF);
        run_stream(1, 1'b1, 1'b0, 1'b0, f, l);
        check("twos_beat0", 64'(f), 64'h00_81_7F_00_FB);

        // Stalls with a start issued mid-stream.
        run_stream(3, 1'b0, 1'b1, 1'b1, f, l);

        // Rejected start and rejected writes.
        bus.start        = 1'b1;
        bus.start_neuron = NW'(12);
        step();
        bus.start = 1'b0;
        check("badstart_err", 64'(bus.err), 64'd1);
        check("badstart_busy", 64'(bus.busy), 64'd0);
        check("badstart_valid", 64'(bus.out_valid), 64'd0);
        step();
        check("badstart_err_pulse", 64'(bus.err), 64'd0);
        write_word(2, 31, 8'hAA);
        step();
        check("badwr_err_pulse", 64'(bus.err), 64'd0);
        write_word(10, 0, 8'h55);
        run_stream(2, 1'b0, 1'b0, 1'b0, f, l);
        run_stream(3, 1'b0, 1'b0, 1'b0, f, l);

        // Read/write collisions on row 4, which is still all zero.
        bus.start        = 1'b1;
        bus.start_neuron = NW'(4);
        bus.cfg_twos     = 1'b0;
        bus.out_ready    = 1'b0;
        step();
        bus.start = 1'b0;
        drive_wr(4, 0, 8'h11);
        step();
        bus.wr_en = 1'b0;
        model[4][0] = 8'h11;
        check("coll_valid", 64'(bus.out_valid), 64'd1);
        check("coll_same_edge", 64'(bus.out_data), 64'd0);
        write_word(4, 1, 8'h22);
        check("coll_presented", 64'(bus.out_data), 64'd0);
        write_word(4, 6, 8'h33);
        check("coll_future_hold", 64'(bus.out_data), 64'd0);
        drive_wr(4, 7, 8'h44);
        bus.out_ready = 1'b1;
        step();
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b0;
        model[4][7] = 8'h44;
        check("coll_beat1_idx", 64'(bus.out_beat), 64'd1);
        check("coll_beat1_data", 64'(bus.out_data), 64'h00_00_00_33_00);
        bus.out_ready = 1'b1;
        guard = 0;
        while (bus.busy && guard < 20) begin
            step();
            guard++;
        end
        bus.out_ready = 1'b0;
        check("coll_drain", 64'(bus.busy), 64'd0);
        run_stream(4, 1'b0, 1'b0, 1'b0, f, l);

        // Random rows, data and modes with stalls and mid-stream starts.
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 20; w++)
                write_word(int'($urandom_range(NN - 1)), int'($urandom_range(NWT - 1)), WW'($urandom));
            run_stream(int'($urandom_range(NN - 1)), 1'($urandom), 1'b1, 1'b1, f, l);
        end

        // Reset in the middle of beat 2.
        bus.start        = 1'b1;
        bus.start_neuron = NW'(3);
        bus.cfg_twos     = 1'b0;
        step();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (!(bus.out_valid && bus.out_beat == 2) && guard < 20) begin
            step();
            guard++;
        end
        check("midrst_reach_beat2", 64'(bus.out_beat), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        clear_model();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b0;
        run_stream(3, 1'b0, 1'b0, 1'b0, f, l);
        check("midrst_row3_first", 64'(f), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
